riscv_hazard_ctrl: RTL
======================

Name: riscv_hazard_ctrl

Overview:
Parametrised successor to the 5-stage core's hazard unit. Keeps operand forwarding, load-use stall and branch flush. Adds two new hazard sources: a variable-latency multicycle EX operation (MUL/DIV) and a data-memory wait handshake with a timeout watchdog. It sits beside the IF/ID/EX/MEM/WB stages, drives every stage's stall and flush, and owns a small FSM with counters.

Parameters:
REG_ADDR_W, 5, register index width
MC_LATENCY, 4, total cycles a multicycle op occupies EX; legal range 2..255
MEM_TIMEOUT, 16, consecutive dmem wait cycles before mem_timeout is set; 0 disables the watchdog
CNT_W, 8, width of the internal counters; must hold max(MC_LATENCY, MEM_TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rs1_d, rs2_d  in  REG_ADDR_W  source registers of the instruction in ID
rs1_e, rs2_e, rd_e  in  REG_ADDR_W  source and destination registers in EX
result_src_e_0  in  1  EX instruction is a load
pc_src_e  in  1  taken branch or jump resolved in EX
mc_start_e  in  1  EX holds a multicycle op; held high while that op sits in EX
rd_m  in  REG_ADDR_W  destination register in MEM
regwrite_m  in  1  MEM instruction writes the register file
mem_access_m  in  1  MEM instruction is a load or store
dmem_ready_m  in  1  data memory completes the access this cycle
rd_w  in  REG_ADDR_W  destination register in WB
regwrite_w  in  1  WB instruction writes the register file
stall_f, stall_d, stall_e, stall_m  out  1  hold the PC / pipeline register
flush_d, flush_e, flush_m, flush_w  out  1  insert a bubble into the stage register
forward_operand_a_e, forward_operand_b_e  out  2  00 regfile, 01 WB, 10 MEM
mc_busy  out  1  multicycle op in progress
mc_done  out  1  last EX cycle of the multicycle op
mem_timeout  out  1  sticky watchdog error

Behaviour:
- Forwarding (combinational): select 10 if regwrite_m, rd_m≠0 and rd_m==rs; else 01 if regwrite_w, rd_w≠0 and rd_w==rs; else 00. MEM wins over WB. Register x0 is never forwarded.
- freeze = mem_access_m & ~dmem_ready_m. While frozen: stall_f/d/e/m=1 and flush_w=1. All other flushes are 0. The MC counter holds its value.
- FSM states are IDLE and MC_BUSY.
- IDLE with mc_start_e & ~freeze:
  - MC_LATENCY>2: load mc_cnt=MC_LATENCY-2, go to MC_BUSY.
  - MC_LATENCY==2: stay in IDLE; the next cycle is the done cycle.
- The start cycle and every MC_BUSY cycle with mc_cnt>0 drive stall_f/d/e=1 and flush_m=1. mc_cnt decrements each non-frozen cycle.
- MC_BUSY with mc_cnt==0: mc_done=1 and stalls drop, so the op advances. Return to IDLE. Total EX occupancy is exactly MC_LATENCY unfrozen cycles.
- mc_busy=1 from the start cycle through the cycle before mc_done.
- A new mc_start_e in the cycle after mc_done is a new op and is accepted.
- The EX unit captures its operands in the start cycle. Forwarding is valid only in that cycle.
- Load-use (only when not frozen and not MC-stalling): result_src_e_0, rd_e≠0 and rd_e matches rs1_d or rs2_d. Drive stall_f=stall_d=1 and flush_e=1.
- Branch (same gating): pc_src_e drives flush_d=1 and flush_e=1. It overrides the load-use stall_f/stall_d in the same cycle.
- Priority order: reset > freeze > MC stall > branch > load-use.
- Watchdog:
  - wait_cnt increments on each frozen cycle and clears on any unfrozen cycle.
  - When wait_cnt reaches MEM_TIMEOUT (and MEM_TIMEOUT≠0), set mem_timeout.
  - mem_timeout stays set until reset. The freeze continues regardless.
- Reset, including mid-MC or mid-wait:
  - State returns to IDLE; mc_cnt, wait_cnt and mem_timeout clear to 0.
  - Outputs during reset: all stalls 0, flush_d/e/m/w=1, forwards 00, mc_busy=0, mc_done=0.

Decomposition:
- Package riscv_pipe_pkg:
  - forwarding encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - FSM state typedef (IDLE, MC_BUSY);
  - the MEM_TIMEOUT-disable constant 0.
- Sub-module riscv_fwd_sel: combinational single-operand forwarding selector, instantiated twice (operands A and B).

Test Plan:
- Forwarding: rd_m=5 with regwrite_m=1, and rd_w=5 with regwrite_w=1, rs1_e=5 -> forward_operand_a_e=10. Clear regwrite_m -> 01. Set rs1_e=0 with rd_m=0 -> 00.
- Load-use: result_src_e_0=1, rd_e=3, rs2_d=3 -> stall_f=stall_d=flush_e=1 for 1 cycle. Same stimulus with pc_src_e=1 -> flush_d=flush_e=1, stall_f=0.
- Multicycle, MC_LATENCY=4: mc_start_e held from cycle 10 -> stall_e=1 and flush_m=1 in cycles 10–12, mc_done=1 in cycle 13, mc_busy=1 in cycles 10–12.
- Freeze inside multicycle: op starts at cycle 10, dmem_ready_m=0 with mem_access_m=1 in cycles 11–12 -> stall_m=flush_w=1 in cycles 11–12, mc_done moves to cycle 15.
- Watchdog, MEM_TIMEOUT=16: dmem_ready_m held 0 -> mem_timeout rises after the 16th frozen cycle and stays 1 after ready returns. Assert reset -> mem_timeout=0.
- Reset mid-MC: assert reset in cycle 11 of an op started at cycle 10 -> state returns to IDLE, mc_busy=0, all flushes=1 during reset, no mc_done afterwards.

Source files
------------

// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared encodings and types for the pipeline hazard controller: forwarding
// selects, the multicycle FSM state type and the watchdog-disable value.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  localparam int unsigned MEM_TIMEOUT_OFF = 0;

endpackage : riscv_pipe_pkg

// File: rtl/riscv_hazard_ctrl_if.sv
// Bundle between the pipeline stages and the hazard controller. The pipeline
// (master) reports register usage and events; the controller (slave) returns stalls/flushes.
interface riscv_hazard_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d;
  logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e;
  logic                  result_src_e_0;
  logic                  pc_src_e;
  logic                  mc_start_e;
  logic [REG_ADDR_W-1:0] rd_m;
  logic                  regwrite_m;
  logic                  mem_access_m;
  logic                  dmem_ready_m;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  regwrite_w;

  logic                  stall_f, stall_d, stall_e, stall_m;
  logic                  flush_d, flush_e, flush_m, flush_w;
  logic [1:0]            forward_operand_a_e, forward_operand_b_e;
  logic                  mc_busy, mc_done, mem_timeout;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e_0, pc_src_e, mc_start_e,
           rd_m, regwrite_m, mem_access_m, dmem_ready_m, rd_w, regwrite_w,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
           forward_operand_a_e, forward_operand_b_e, mc_busy, mc_done, mem_timeout
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, result_src_e_0, pc_src_e, mc_start_e,
           rd_m, regwrite_m, mem_access_m, dmem_ready_m, rd_w, regwrite_w,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
           forward_operand_a_e, forward_operand_b_e, mc_busy, mc_done, mem_timeout
  );

endinterface : riscv_hazard_if

// File: rtl/riscv_hazard_ctrl_fwd_sel.sv
// Single-operand forwarding selector: the youngest in-flight writer wins and
// x0 is never forwarded because it always reads as zero.
module riscv_fwd_sel
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  regwrite_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_w,
  output logic [1:0]            fwd
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    fwd = FWD_RF;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) begin
      fwd = FWD_M;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs)) begin
      fwd = FWD_W;
    end
  end

endmodule : riscv_fwd_sel

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// multicycle EX sequencing and a data-memory wait watchdog.
module riscv_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MC_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           reset,
  riscv_hazard_if.slave  hz
);

  localparam logic [CNT_W-1:0] MC_LOAD     = CNT_W'(MC_LATENCY - 2);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);
  localparam bit               SHORT_MC    = (MC_LATENCY == 2);
  localparam bit               WD_EN       = (MEM_TIMEOUT != int'(MEM_TIMEOUT_OFF));

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             done_pend_q, done_pend_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic       freeze, mc_start, mc_hold, mc_done_cycle, mc_done_i, load_use;
  logic [1:0] fwd_a, fwd_b;

  riscv_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(hz.rs1_e), .rd_m(hz.rd_m), .regwrite_m(hz.regwrite_m),
    .rd_w(hz.rd_w), .regwrite_w(hz.regwrite_w), .fwd(fwd_a)
  );

  riscv_fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(hz.rs2_e), .rd_m(hz.rd_m), .regwrite_m(hz.regwrite_m),
    .rd_w(hz.rd_w), .regwrite_w(hz.regwrite_w), .fwd(fwd_b)
  );

  // With MC_LATENCY==2 the FSM stays in IDLE and done_pend marks the done cycle.
  always_comb begin
    freeze        = hz.mem_access_m & ~hz.dmem_ready_m;
    mc_start      = (state_q == IDLE) && !done_pend_q && hz.mc_start_e && !freeze;
    mc_hold       = (state_q == MC_BUSY) && (mc_cnt_q != '0);
    mc_done_cycle = ((state_q == MC_BUSY) && (mc_cnt_q == '0)) ||
                    ((state_q == IDLE) && done_pend_q);
    mc_done_i     = mc_done_cycle && !freeze;
    load_use      = hz.result_src_e_0 && (hz.rd_e != '0) &&
                    ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));

    state_d     = state_q;
    mc_cnt_d    = mc_cnt_q;
    done_pend_d = done_pend_q;
    if (!freeze) begin
      if (mc_start) begin
        if (SHORT_MC) begin
          done_pend_d = 1'b1;
        end else begin
          state_d  = MC_BUSY;
          mc_cnt_d = MC_LOAD;
        end
      end else if (mc_done_i) begin
        state_d     = IDLE;
        done_pend_d = 1'b0;
      end else if (mc_hold) begin
        mc_cnt_d = mc_cnt_q - 1'b1;
      end
    end

    // Saturate rather than wrap so a very long wait cannot alias back to zero.
    if (!freeze)               wait_cnt_d = '0;
    else if (&wait_cnt_q)      wait_cnt_d = wait_cnt_q;
    else                       wait_cnt_d = wait_cnt_q + 1'b1;
    mem_timeout_d = mem_timeout_q | (WD_EN && freeze && (wait_cnt_d == TIMEOUT_VAL));
  end

  always_comb begin
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.stall_e = 1'b0;
    hz.stall_m = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    hz.flush_m = 1'b0;
    hz.flush_w = 1'b0;
    hz.forward_operand_a_e = fwd_a;
    hz.forward_operand_b_e = fwd_b;
    hz.mc_busy     = mc_start || (((state_q == MC_BUSY) || done_pend_q) && !mc_done_i);
    hz.mc_done     = mc_done_i;
    hz.mem_timeout = mem_timeout_q;

    if (reset) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
      hz.flush_m = 1'b1;
      hz.flush_w = 1'b1;
      hz.forward_operand_a_e = FWD_RF;
      hz.forward_operand_b_e = FWD_RF;
      hz.mc_busy = 1'b0;
      hz.mc_done = 1'b0;
    end else if (freeze) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.stall_e = 1'b1;
      hz.stall_m = 1'b1;
      hz.flush_w = 1'b1;
    end else if (mc_start || mc_hold) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.stall_e = 1'b1;
      hz.flush_m = 1'b1;
    end else if (hz.pc_src_e) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
    end else if (load_use) begin
      hz.stall_f = 1'b1;
      hz.stall_d = 1'b1;
      hz.flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q       <= IDLE;
      mc_cnt_q      <= '0;
      wait_cnt_q    <= '0;
      done_pend_q   <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mc_cnt_q      <= mc_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      done_pend_q   <= done_pend_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

endmodule : riscv_hazard_ctrl
